// File: rtl/decoupled_fetch_unit.sv
// decoupled_fetch_unit
//   Front-end pc generator feeding a small fetch queue. The pc register
//   drives a synchronous i-cache through pc_next; every pc that gets
//   fetched is pushed with its branch prediction into a circular queue
//   that the decode side drains with a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   stall               freeze pc and the queue write side
//   redirect_we/_pc     redirect strobe and target; overrides stall, flushes queue
//   bp_is_branch/_taken/_target  predictor result for pc_current
//   pc_current          registered fetch pc
//   pc_next             combinational next pc (i-cache address)
//   out_valid/_ready    queue head handshake
//   out_pc/_pred_taken/_pred_target  queue head contents
//   count               queue occupancy
module decoupled_fetch_unit #(
  parameter int                    ADDR_WIDTH = 26,
  parameter int                    QDEPTH     = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        redirect_we,
  input  logic [ADDR_WIDTH-1:0]       redirect_pc,
  input  logic                        bp_is_branch,
  input  logic                        bp_taken,
  input  logic [ADDR_WIDTH-1:0]       bp_target,
  output logic [ADDR_WIDTH-1:0]       pc_current,
  output logic [ADDR_WIDTH-1:0]       pc_next,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_WIDTH-1:0]       out_pc,
  output logic                        out_pred_taken,
  output logic [ADDR_WIDTH-1:0]       out_pred_target,
  output logic [$clog2(QDEPTH):0]     count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
  } entry_t;

  entry_t          mem [QDEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            pop, push, taken;
  entry_t          head;

  assign taken     = bp_is_branch & bp_taken;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign push      = !stall & !redirect_we & ((count < FULL) | pop);

  always_comb begin
    pc_next = pc_current + ADDR_WIDTH'(4);
    if (redirect_we)         pc_next = redirect_pc;
    else if (stall || !push) pc_next = pc_current;  // hold so no fetched pc is dropped
    else if (taken)          pc_next = bp_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_current <= RESET_PC;
    else        pc_current <= pc_next;
  end

  // Storage has no reset; occupancy alone decides what is valid.
  // The target is stored as zero for not-taken entries so the head reads 0.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pc_current, taken: taken,
                               target: taken ? bp_target : '0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_we) begin
      // Flush; a concurrent pop is simply dropped with everything else.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head            = mem[rd_ptr];
  assign out_pc          = head.pc;
  assign out_pred_taken  = head.taken;
  assign out_pred_target = head.target;

endmodule

// File: doc/decoupled_fetch_unit.md
DECOUPLED_FETCH_UNIT -- requirements
Module: decoupled_fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 26, sets the byte-address width of every pc field.
REQ-002 Parameter QDEPTH, default 4, sets the fetch-queue entry count; legal values are powers of two >= 2.
REQ-003 Parameter RESET_PC, default 0, sets the pc loaded at reset.
REQ-004 Port clk, input, 1: clock; all state updates on posedge.
REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 Port stall, input, 1: hazard stall; while high, pc and queue-write side freeze.
REQ-007 Port redirect_we, input, 1: resolved-branch or exception redirect strobe.
REQ-008 Port redirect_pc, input, ADDR_WIDTH: redirect target.
REQ-009 Port bp_is_branch, input, 1: predictor marks pc_current as a branch.
REQ-010 Port bp_taken, input, 1: predictor direction for pc_current.
REQ-011 Port bp_target, input, ADDR_WIDTH: predicted target for pc_current.
REQ-012 Port pc_current, output, ADDR_WIDTH: registered pc being fetched this cycle.
REQ-013 Port pc_next, output, ADDR_WIDTH: combinational pc for the next cycle, fed to the synchronous i-cache.
REQ-014 Port out_valid, output, 1: queue head holds a valid entry.
REQ-015 Port out_ready, input, 1: consumer accepts the head this cycle.
REQ-016 Port out_pc, output, ADDR_WIDTH: pc of the queue head.
REQ-017 Port out_pred_taken, output, 1: predicted-taken flag of the queue head.
REQ-018 Port out_pred_target, output, ADDR_WIDTH: predicted target of the queue head; 0 when the flag is 0.
REQ-019 Port count, output, $clog2(QDEPTH)+1: current occupancy.

Function
REQ-020 The queue SHALL be a circular buffer with rd/wr pointers of $clog2(QDEPTH) bits that wrap modulo QDEPTH, plus a separate occupancy counter.
REQ-021 pop = out_valid & out_ready; out_valid = (count != 0).
REQ-022 push = !stall & !redirect_we & (count < QDEPTH | pop); a push writes {pc_current, taken, target} with taken = bp_is_branch & bp_taken.
REQ-023 pc_next SHALL be selected by priority: redirect_we -> redirect_pc; else stall or !push -> pc_current; else taken -> bp_target; else pc_current + 4, truncated to ADDR_WIDTH.
REQ-024 redirect_we SHALL override stall; the redirect takes effect the same cycle, matching the existing load-pc-over-stall behaviour.
REQ-025 pc_current SHALL load pc_next every posedge; fetch pc latency is one cycle.
REQ-026 Redirect flush: on a redirect_we cycle, the cycle ends with rd_ptr = wr_ptr = 0, count = 0, no push, and any concurrent pop still counted as consumed.
REQ-027 Full: when count == QDEPTH and no pop, push = 0 and pc holds, so no fetched pc is dropped.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, including at full and at count = 1.
REQ-029 Empty: a pushed entry SHALL appear at out_* on the following cycle; there is no same-cycle bypass.
REQ-030 out_pc, out_pred_taken and out_pred_target SHALL be held stable while out_valid & !out_ready.
REQ-031 count SHALL never exceed QDEPTH or underflow below 0.

Reset
REQ-032 While rst_n = 0 at posedge: pc_current = RESET_PC, pointers = 0, count = 0, out_valid = 0; storage contents are don't-care.
REQ-033 Reset SHALL take precedence over redirect_we, stall and pop; a reset asserted mid-operation discards all queued entries.
REQ-034 In the first cycle after reset release, pc_next = RESET_PC + 4 if no stall/redirect/branch and the queue is not full.

Verification
REQ-035 Reset release, stall = 0, out_ready = 1, no branches -> out_pc sequence 0x0, 0x4, 0x8, ... one entry per cycle from cycle 2; count stays at 1.
REQ-036 out_ready = 0 with QDEPTH = 4 -> count reaches 4 after 4 pushes; pc_current holds at 0x10; then out_ready = 1 for one cycle -> one pop and one push, and count stays at 4.
REQ-037 bp_is_branch = bp_taken = 1 with bp_target = 0x100 at pc_current = 0x8 -> the entry for 0x8 carries out_pred_taken = 1 and out_pred_target = 0x100; the next entry is 0x100.
REQ-038 With 3 entries queued and stall = 1, assert redirect_we with redirect_pc = 0x200 -> next cycle count = 0, out_valid = 0, pc_current = 0x200; the next entry is 0x200.
REQ-039 Pointer wrap: run 3*QDEPTH+1 pushes with random out_ready -> out_pc order matches push order exactly.
REQ-040 rst_n = 0 for one cycle with the queue full -> count = 0, out_valid = 0, pc_current = RESET_PC.
